// File: rtl/vram_pkg.sv
// Shared VRAM definitions for the arbiter, the video fetch engine and the CPU bus decoder.
package vram_pkg;

   localparam int VRAM_ADDR_W = 13;
   localparam int VRAM_DATA_W = 8;

   // Owner of the return slot, one cycle after the grant.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_e;

endpackage : vram_pkg

// File: rtl/vram_starve_timer.sv
// Counts cycles an eligible CPU request is refused and raises force_cpu once the
// refusal count reaches STARVE_LIMIT (STARVE_LIMIT = 0 disables forcing).
module vram_starve_timer #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic dot_clk,
   input  logic reset,
   input  logic cpu_req,
   input  logic cpu_eligible,
   input  logic cpu_grant,
   output logic force_cpu
);

   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge dot_clk) begin
      if (reset) begin
         starve <= '0;
      end else if (!cpu_req || cpu_grant) begin
         starve <= '0;
      end else if (cpu_eligible && (starve != LIMIT)) begin
         starve <= starve + 1'b1;
      end
   end

   assign force_cpu = (STARVE_LIMIT != 0) && cpu_eligible && (starve == LIMIT);

endmodule : vram_starve_timer

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches win by default, the starve timer bounds
// CPU latency, and every access returns data exactly one cycle after its grant.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W       = VRAM_ADDR_W,
   parameter int DATA_W       = VRAM_DATA_W,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              dot_clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   owner_e            owner;
   owner_e            owner_nxt;
   logic              owner_we;
   logic              cpu_busy;
   logic              cpu_eligible;
   logic              force_cpu;
   logic              cpu_grant;
   logic              vid_grant;
   logic [DATA_W-1:0] cpu_rdata_q;

   assign cpu_eligible = cpu_req && !cpu_busy;

   vram_starve_timer #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_timer (
      .dot_clk      (dot_clk),
      .reset        (reset),
      .cpu_req      (cpu_req),
      .cpu_eligible (cpu_eligible),
      .cpu_grant    (cpu_grant),
      .force_cpu    (force_cpu)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      cpu_grant = 1'b0;
      vid_grant = 1'b0;
      owner_nxt = OWN_NONE;
      if (!reset) begin
         if (force_cpu || (cpu_eligible && !vid_req)) begin
            cpu_grant = 1'b1;
            owner_nxt = OWN_CPU;
         end else if (vid_req) begin
            vid_grant = 1'b1;
            owner_nxt = OWN_VID;
         end
      end
   end

   always_ff @(posedge dot_clk) begin
      if (reset) begin
         owner    <= OWN_NONE;
         owner_we <= 1'b0;
      end else begin
         owner    <= owner_nxt;
         owner_we <= cpu_grant && cpu_we;
      end
   end

   // Busy spans grant-to-ack so the CPU cannot be re-granted in its own ack cycle.
   always_ff @(posedge dot_clk) begin
      if (reset) begin
         cpu_busy <= 1'b0;
      end else if (cpu_grant) begin
         cpu_busy <= 1'b1;
      end else if (owner == OWN_CPU) begin
         cpu_busy <= 1'b0;
      end
   end

   assign mem_addr  = cpu_grant ? cpu_addr : vid_addr;
   assign mem_we    = cpu_grant && cpu_we;
   assign mem_wdata = cpu_wdata;
   assign vid_ack   = vid_grant;

   assign vid_rvalid = (owner == OWN_VID);
   assign vid_rdata  = mem_rdata;
   assign cpu_ack    = (owner == OWN_CPU);

   // Read data passes straight through on a CPU read ack, otherwise the last value is held.
   always_comb begin
      cpu_rdata = cpu_rdata_q;
      if ((owner == OWN_CPU) && !owner_we) begin
         cpu_rdata = mem_rdata;
      end
   end

   always_ff @(posedge dot_clk) begin
      if (reset) begin
         cpu_rdata_q <= '0;
      end else begin
         cpu_rdata_q <= cpu_rdata;
      end
   end

endmodule : vram_arbiter

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the scan-out fetch engine and the CPU bus inside the computer, on the dot clock domain.
- Video fetches have priority so the pixel pipeline meets its deadline.
- A bounded-starvation counter guarantees CPU progress.
- The block sequences every memory cycle: address and write-enable muxing, return routing of read data, and per-requester handshakes.

Parameters:
- ADDR_W, 13, VRAM word address width.
- DATA_W, 8, VRAM data width.
- STARVE_LIMIT, 8, cycles a pending CPU request may be refused before it pre-empts video. 0 = strict video priority, CPU never forced.

Ports:
- dot_clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  video fetch request for this cycle.
- vid_addr  in  ADDR_W  video fetch address.
- vid_ack  out  1  combinational; fetch accepted this cycle.
- vid_rvalid  out  1  registered; vid_rdata valid.
- vid_rdata  out  DATA_W  fetched data.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  registered single-cycle pulse; access complete.
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack on reads.
- mem_addr  out  ADDR_W  VRAM address.
- mem_we  out  1  VRAM write enable.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, one cycle after address.

Behaviour:
- Reset values:
  - vid_rvalid=0, cpu_ack=0, mem_we=0.
  - Internal owner register = NONE, cpu_busy=0, starve counter=0.
  - vid_ack=0 while reset is high.
  - An in-flight access is abandoned; no ack is issued for it.
- Each cycle N, the grant decision is combinational from the registered state:
  - cpu_eligible = cpu_req && !cpu_busy.
  - force = cpu_eligible && STARVE_LIMIT!=0 && starve==STARVE_LIMIT.
  - Grant CPU if force, or if cpu_eligible && !vid_req.
  - Else grant video if vid_req.
  - Else no grant.
- Memory drive:
  - Video grant: mem_addr=vid_addr, mem_we=0, vid_ack=1.
  - CPU grant: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata, vid_ack=0.
  - No grant: mem_we=0, mem_addr don't-care.
- Owner register holds NONE, VID or CPU: the owner of the return slot in cycle N+1.
- Return, cycle N+1:
  - Owner VID: vid_rvalid=1, vid_rdata=mem_rdata.
  - Owner CPU: cpu_ack=1; on reads cpu_rdata=mem_rdata, on writes cpu_rdata holds its previous value.
  - Fixed one-cycle latency for both requesters; one access per cycle; full throughput for back-to-back video.
- CPU handshake:
  - cpu_busy is set on CPU grant and cleared in the cycle after cpu_ack.
  - The CPU is never granted in the ack cycle.
  - cpu_req high in cycle N+2 or later is a new transaction. The requester changes cpu_addr, cpu_we and cpu_wdata only after ack.
- Starve counter:
  - Increments when cpu_eligible && not granted, saturating at STARVE_LIMIT.
  - Clears on CPU grant, or when cpu_req is low.
- Simultaneous events:
  - Video and CPU both requesting without force: video wins and the counter increments.
  - When force is set, video is refused for exactly one cycle. The video requester must hold vid_req and vid_addr until vid_ack.
- reset asserted mid-access: the return slot is discarded and outputs take reset values on the next edge.

Decomposition:
- Package vram_pkg holds:
  - the owner enumeration {OWN_NONE, OWN_VID, OWN_CPU};
  - default ADDR_W and DATA_W localparams, shared with the video fetch engine and CPU bus decoder.
- One sub-module, vram_starve_timer: the saturating counter plus the force output, parameterised by STARVE_LIMIT.
- The grant mux and return routing stay in vram_arbiter.

Test Plan:
- Reset then idle: after the reset pulse, all acks=0 and mem_we=0 for 10 cycles with no requests.
- Video stream: vid_req held high for addresses 0x0000–0x000F, with VRAM preloaded with addr&0xFF. Required: vid_ack every cycle, and vid_rvalid with data 0x00…0x0F each one cycle later, with no gaps.
- CPU write then read with video idle:
  - Write 0xA5 to 0x0123: mem_we pulses one cycle, cpu_ack follows one cycle later.
  - Read of 0x0123 issued two cycles after grant: cpu_ack with cpu_rdata=0xA5.
- Starvation with STARVE_LIMIT=8: vid_req held continuously while a CPU read is pending from cycle 0.
  - CPU granted on cycle 8, vid_ack=0 on that cycle only, cpu_ack on cycle 9.
  - Video resumes on cycle 9 with no lost fetch.
- Strict priority with STARVE_LIMIT=0: vid_req held for 50 cycles means no CPU grant. Dropping vid_req gives a CPU grant in the same cycle and cpu_ack on the next.
- Reset mid-op: assert reset in the cycle of a CPU grant. Required: no cpu_ack, no vid_rvalid, and mem_we=0 on the following cycle.
